// File: rtl/demux_router_if.sv
// demux_router_if -- bundle of the source handshake and the per-channel
// output bus of demux_router.
//
// Valid/ready rule used on every handshake of this bus: a transfer happens
// on a rising clock edge where valid and ready are both high. in_ready never
// depends on in_valid. A slot offered on out_valid holds its data stable
// until the edge that transfers it.
//
// Signals:
//   in_valid   source offers a transfer
//   in_ready   router accepts a transfer this cycle
//   in_data    payload (WIDTH)
//   in_sel     destination channel index (SEL_W)
//   in_bcast   deliver payload to every channel, in_sel ignored
//   out_valid  per-channel slot holds data (CHANNELS)
//   out_ready  per-channel consumer accepts (CHANNELS)
//   out_data   channel k in bits [k*WIDTH +: WIDTH]
//   sel_err    sticky flag: an out-of-range select was seen
//   drop_count saturating count of dropped out-of-range transfers
//
// Modports: slave = the router, master = the source/consumer side.
interface demux_router_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_bcast;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      sel_err;
    logic [7:0]                drop_count;

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, sel_err, drop_count
    );

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, sel_err, drop_count
    );
endinterface

// File: rtl/demux_router.sv
// demux_router -- routes one input stream to CHANNELS outputs, each with a
// one-entry holding slot. Unicast goes to the slot selected by in_sel,
// broadcast writes every slot at once (only when all can take it), and
// out-of-range selects are consumed, flagged and counted.
//
// Ports:
//   clk    single clock, all state on the rising edge
//   reset  synchronous, active-high; empties every slot and clears status
//   bus    demux_router_if.slave (handshake, payload, outputs, status)
module demux_router #(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 4,
    parameter int SEL_W     = 2,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    demux_router_if.slave   bus
);

    logic [CHANNELS-1:0] full;
    logic [WIDTH-1:0]    data_q [CHANNELS];
    logic [CHANNELS-1:0] chan_open;
    logic [CHANNELS-1:0] load;
    logic                sel_ok;
    logic                sel_open;
    logic                ready;
    logic                take;
    logic                drop;
    logic                sel_err_q;
    logic [7:0]          drop_q;

    // A slot can take new data if it is empty or is being drained in the
    // same cycle (drain and refill at one edge).
    assign chan_open = ~full | bus.out_ready;

    always_comb begin
        sel_ok   = 1'b0;
        sel_open = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_ok   = 1'b1;
                sel_open = chan_open[k];
            end
        end

        // Broadcast is all-or-nothing; out-of-range unicast is always
        // accepted so the source never deadlocks on a bad select.
        if (reset)
            ready = 1'b0;
        else if (bus.in_bcast)
            ready = &chan_open;
        else if (sel_ok)
            ready = sel_open;
        else
            ready = 1'b1;

        take = bus.in_valid && ready;
        drop = take && !bus.in_bcast && !sel_ok;

        load = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            load[k] = take && (bus.in_bcast || (bus.in_sel == SEL_W'(k)));
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < CHANNELS; k++) begin
            if (reset) begin
                full[k]   <= 1'b0;
                data_q[k] <= '0;
            end else if (load[k]) begin
                full[k]   <= 1'b1;
                data_q[k] <= bus.in_data;
            end else if (bus.out_ready[k]) begin
                full[k]   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
            drop_q    <= 8'd0;
        end else if (drop) begin
            sel_err_q <= 1'b1;
            if (drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
        end
    end

    // With ZERO_IDLE the lane is masked while its slot is empty; otherwise
    // the last stored value stays visible.
    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ZERO_IDLE && !full[k])
                bus.out_data[k*WIDTH +: WIDTH] = '0;
            else
                bus.out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = full;
    assign bus.sel_err    = sel_err_q;
    assign bus.drop_count = drop_q;

endmodule

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, data bits per transfer.
REQ-002 The block SHALL have parameter CHANNELS, default 4, number of output channels (2..16).
REQ-003 The block SHALL have parameter SEL_W, default 2, select width; CHANNELS <= 2**SEL_W.
REQ-004 The block SHALL have parameter ZERO_IDLE, default 1; 1 = out_data lane reads zero while its out_valid is low.
REQ-005 The block SHALL have ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source offers a transfer.
- in_ready  output  1  block accepts a transfer this cycle.
- in_data  input  WIDTH  payload.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  deliver payload to all channels; in_sel ignored.
- out_valid  output  CHANNELS  per-channel slot holds data.
- out_ready  input  CHANNELS  per-channel consumer accepts.
- out_data  output  CHANNELS*WIDTH  channel k in bits [k*WIDTH +: WIDTH].
- sel_err  output  1  sticky: a transfer with in_sel >= CHANNELS was seen.
- drop_count  output  8  number of dropped (invalid-select) transfers.

Function
REQ-006 Each channel SHALL own a one-entry holding slot (data register plus full flag); out_valid[k] equals full flag k.
REQ-007 Channel k SHALL be "open" when its slot is empty or out_ready[k] is high in the same cycle.
REQ-008 For unicast (in_bcast=0, in_sel < CHANNELS), in_ready SHALL equal open[in_sel].
REQ-009 For broadcast (in_bcast=1), in_ready SHALL be high only when every channel is open; never a partial broadcast.
REQ-010 For unicast with in_sel >= CHANNELS, in_ready SHALL be high; the transfer is consumed, no slot written.
REQ-011 A transfer SHALL occur on a rising edge with in_valid && in_ready; in_ready depends combinationally on in_valid-independent signals only (in_sel, in_bcast, slot state, out_ready).
REQ-012 Latency SHALL be one cycle: data accepted at edge N appears on out_data with out_valid high after edge N.
REQ-013 A slot SHALL drain at an edge where out_valid[k] && out_ready[k]; simultaneous drain and refill of the same slot SHALL leave it full with the new data.
REQ-014 out_data for a full slot SHALL remain stable until its drain edge.
REQ-015 With ZERO_IDLE=1, empty-slot lanes of out_data SHALL read zero; with ZERO_IDLE=0 they SHALL hold the last stored value.
REQ-016 An invalid-select transfer SHALL set sel_err (cleared only by reset) and increment drop_count, saturating at 255.
REQ-017 Channels SHALL be independent: a stalled channel SHALL not block unicast to other channels.
REQ-018 Order per channel SHALL be preserved; no transfer is duplicated or lost except REQ-010 drops.

Reset
REQ-019 While reset is high at a rising edge, all slots SHALL empty: out_valid=0, stored data=0, sel_err=0, drop_count=0.
REQ-020 During reset, in_ready SHALL be low; a transfer offered in the reset cycle SHALL be discarded and not counted.
REQ-021 Reset asserted mid-operation SHALL discard all held data with no out_valid pulse on the following cycle.

Verification
REQ-022 Unicast: in_data=4'hA, in_sel=2, out_ready=4'b1111 -> next cycle out_valid=4'b0100, lane 2 = 4'hA, other lanes 0, slot drains the cycle after.
REQ-023 Backpressure: out_ready[1]=0, two unicasts to channel 1 (4'h3 then 4'h5) -> first accepted, in_ready low for second until out_ready[1]=1; lane 1 shows 4'h3 then 4'h5, nothing lost.
REQ-024 Broadcast blocked: channel 3 full with out_ready[3]=0, in_bcast=1 data 4'h7 -> in_ready=0, no slot changes; raise out_ready[3] -> accepted, all four lanes = 4'h7 next cycle.
REQ-025 Invalid select: CHANNELS=3, in_sel=3, 260 transfers -> in_ready=1 throughout, out_valid stays 0, sel_err=1, drop_count=255.
REQ-026 Reset mid-stream: slots 0 and 2 full, assert reset one cycle -> out_valid=0, out_data=0, sel_err=0, drop_count=0, in_ready low during reset.
